// File: rtl/pc_fetch_sequencer.sv
// Next-PC controller: owns the fetch address, issues it over valid/ready,
// arbitrates redirects and kills responses fetched before a redirect.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          CNT_W           = 2
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_trap_valid,
    input  logic [31:0]      I_trap_pc,
    input  logic             I_br_valid,
    input  logic [31:0]      I_br_pc,
    input  logic             I_stall,
    output logic             O_pc_valid,
    output logic [31:0]      O_pc,
    input  logic             I_pc_ready,
    input  logic             I_rsp_valid,
    output logic             O_rsp_kill,
    output logic             O_flush,
    output logic [CNT_W-1:0] O_outstanding
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] kill_q, kill_d;

    logic        redir;
    logic [31:0] target;
    logic        issue_ok;
    logic        hs;
    logic        rsp_ok;

    // Gating with I_rst_n keeps flush/kill quiet while reset is held.
    assign redir  = I_rst_n && (I_trap_valid || I_br_valid);
    assign target = I_trap_valid ? {I_trap_pc[31:1], 1'b0} : {I_br_pc[31:1], 1'b0};

    assign issue_ok = (state_q != ST_BOOT) && !I_stall && !redir
                      && (out_q < CNT_W'(MAX_OUTSTANDING));
    assign hs       = issue_ok && I_pc_ready;

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_ok = I_rsp_valid && (out_q != '0);

    assign O_pc_valid    = issue_ok;
    assign O_pc          = pc_q;
    assign O_flush       = redir;
    assign O_rsp_kill    = rsp_ok && ((kill_q != '0) || redir);
    assign O_outstanding = out_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q + CNT_W'(hs) - CNT_W'(rsp_ok);
        kill_d  = kill_q;

        if (hs) begin
            pc_d = pc_q + 32'd4;
        end

        if (redir) begin
            pc_d    = target;
            state_d = ST_REDIR;
            kill_d  = out_q - CNT_W'(rsp_ok);
        end else begin
            if (rsp_ok && (kill_q != '0)) begin
                kill_d = kill_q - CNT_W'(1);
            end
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_REDIR: if (hs) state_d = ST_RUN;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            kill_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            kill_q  <= kill_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: inputs change 1 time unit after the
// rising edge, outputs are checked 3 units after it.
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        br_valid;
    logic [31:0] br_pc;
    logic        stall;
    logic        pc_valid;
    logic [31:0] pc;
    logic        pc_ready;
    logic        rsp_valid;
    logic        rsp_kill;
    logic        flush;
    logic [1:0]  outstanding;

    int n_total = 0;
    int n_bad   = 0;

    pc_fetch_sequencer #(
        .RESET_PC       (32'h8000_0000),
        .MAX_OUTSTANDING(2),
        .CNT_W          (2)
    ) dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_trap_valid (trap_valid),
        .I_trap_pc    (trap_pc),
        .I_br_valid   (br_valid),
        .I_br_pc      (br_pc),
        .I_stall      (stall),
        .O_pc_valid   (pc_valid),
        .O_pc         (pc),
        .I_pc_ready   (pc_ready),
        .I_rsp_valid  (rsp_valid),
        .O_rsp_kill   (rsp_kill),
        .O_flush      (flush),
        .O_outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0; trap_valid = 1'b0; trap_pc = '0; br_valid = 1'b0; br_pc = '0;
        stall = 1'b0; pc_ready = 1'b0; rsp_valid = 1'b0;

        // Reset state, with a redirect and a response asserted during reset
        tick(); trap_valid = 1'b1; trap_pc = 32'h1234_5678; rsp_valid = 1'b1; settle();
        chk("rst_valid", 32'(pc_valid), 32'd0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_out", 32'(outstanding), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_kill", 32'(rsp_kill), 32'd0);
        trap_valid = 1'b0; rsp_valid = 1'b0;

        // Sequential fetch with a response one cycle after each handshake
        tick(); rst_n = 1'b1; pc_ready = 1'b1; settle();
        chk("boot_valid", 32'(pc_valid), 32'd0);
        tick(); settle();
        chk("seq0_valid", 32'(pc_valid), 32'd1);
        chk("seq0_pc", pc, 32'h8000_0000);
        tick(); rsp_valid = 1'b1; settle();
        chk("seq1_pc", pc, 32'h8000_0004);
        chk("seq1_valid", 32'(pc_valid), 32'd1);
        chk("seq1_kill", 32'(rsp_kill), 32'd0);
        tick(); settle();
        chk("seq2_pc", pc, 32'h8000_0008);
        chk("seq2_kill", 32'(rsp_kill), 32'd0);
        tick(); pc_ready = 1'b0; settle();
        chk("seq3_kill", 32'(rsp_kill), 32'd0);
        chk("seq3_out", 32'(outstanding), 32'd1);

        // Outstanding limit
        tick(); rsp_valid = 1'b0; pc_ready = 1'b1; settle();
        chk("lim_a_pc", pc, 32'h8000_000C);
        tick(); settle();
        chk("lim_b_valid", 32'(pc_valid), 32'd1);
        tick(); settle();
        chk("lim_c_valid", 32'(pc_valid), 32'd0);
        chk("lim_c_out", 32'(outstanding), 32'd2);
        tick(); rsp_valid = 1'b1; settle();
        chk("lim_d_kill", 32'(rsp_kill), 32'd0);
        tick(); rsp_valid = 1'b0; pc_ready = 1'b0; settle();
        chk("lim_e_valid", 32'(pc_valid), 32'd1);
        chk("lim_e_out", 32'(outstanding), 32'd1);
        tick(); pc_ready = 1'b1; settle();
        chk("lim_f_pc", pc, 32'h8000_0014);

        // Branch redirect with two fetches in flight
        tick(); br_valid = 1'b1; br_pc = 32'h8000_1003; settle();
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_valid", 32'(pc_valid), 32'd0);
        tick(); br_valid = 1'b0; pc_ready = 1'b0; settle();
        chk("br_pc", pc, 32'h8000_1002);
        chk("br_out", 32'(outstanding), 32'd2);
        chk("br_flush_off", 32'(flush), 32'd0);
        tick(); rsp_valid = 1'b1; settle();
        chk("br_kill1", 32'(rsp_kill), 32'd1);
        tick(); settle();
        chk("br_kill2", 32'(rsp_kill), 32'd1);
        tick(); rsp_valid = 1'b0; pc_ready = 1'b1; settle();
        chk("br_tgt_valid", 32'(pc_valid), 32'd1);
        chk("br_tgt_pc", pc, 32'h8000_1002);
        tick(); rsp_valid = 1'b1; pc_ready = 1'b0; settle();
        chk("br_kill3", 32'(rsp_kill), 32'd0);
        chk("br_next_pc", pc, 32'h8000_1006);

        // Simultaneous trap and branch, then branch overwrites pending target
        tick(); rsp_valid = 1'b0; pc_ready = 1'b1;
        trap_valid = 1'b1; trap_pc = 32'h8000_0100; br_valid = 1'b1; br_pc = 32'h8000_2000; settle();
        chk("tb_flush", 32'(flush), 32'd1);
        chk("tb_valid", 32'(pc_valid), 32'd0);
        tick(); trap_valid = 1'b0; br_valid = 1'b0; pc_ready = 1'b0; settle();
        chk("tb_pc", pc, 32'h8000_0100);
        chk("tb_redir_valid", 32'(pc_valid), 32'd1);
        tick(); br_valid = 1'b1; br_pc = 32'h8000_2000; settle();
        chk("tb_over_flush", 32'(flush), 32'd1);
        tick(); br_valid = 1'b0; settle();
        chk("tb_over_pc", pc, 32'h8000_2000);

        // Redirect coincident with a response at outstanding=2
        tick(); pc_ready = 1'b1; settle();
        chk("co_a_pc", pc, 32'h8000_2000);
        tick(); settle();
        chk("co_b_pc", pc, 32'h8000_2004);
        tick(); pc_ready = 1'b0; br_valid = 1'b1; br_pc = 32'h8000_3000; rsp_valid = 1'b1; settle();
        chk("co_out", 32'(outstanding), 32'd2);
        chk("co_kill_same", 32'(rsp_kill), 32'd1);
        tick(); br_valid = 1'b0; settle();
        chk("co_out_after", 32'(outstanding), 32'd1);
        chk("co_kill_next", 32'(rsp_kill), 32'd1);
        tick(); rsp_valid = 1'b0; pc_ready = 1'b1; settle();
        chk("co_tgt_pc", pc, 32'h8000_3000);
        chk("co_tgt_valid", 32'(pc_valid), 32'd1);
        tick(); rsp_valid = 1'b1; pc_ready = 1'b0; settle();
        chk("co_kill_last", 32'(rsp_kill), 32'd0);

        // Response with nothing outstanding is ignored
        tick(); settle();
        chk("perr_out", 32'(outstanding), 32'd0);
        chk("perr_kill", 32'(rsp_kill), 32'd0);
        tick(); rsp_valid = 1'b0; settle();
        chk("perr_out_after", 32'(outstanding), 32'd0);

        // Stall for five cycles
        stall = 1'b1; pc_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            chk("stall_valid", 32'(pc_valid), 32'd0);
        end
        chk("stall_out", 32'(outstanding), 32'd0);
        tick(); stall = 1'b0; settle();
        chk("stall_resume_valid", 32'(pc_valid), 32'd1);
        chk("stall_resume_pc", pc, 32'h8000_3004);

        // Reset pulsed while in REDIR
        tick(); pc_ready = 1'b0; br_valid = 1'b1; br_pc = 32'h8000_4000; settle();
        tick(); br_valid = 1'b0; settle();
        chk("mr_pc_before", pc, 32'h8000_4000);
        chk("mr_out_before", 32'(outstanding), 32'd1);
        rst_n = 1'b0; pc_ready = 1'b1; rsp_valid = 1'b1; #1;
        chk("mr_valid", 32'(pc_valid), 32'd0);
        chk("mr_pc", pc, 32'h8000_0000);
        chk("mr_out", 32'(outstanding), 32'd0);
        chk("mr_kill", 32'(rsp_kill), 32'd0);
        tick(); rsp_valid = 1'b0; rst_n = 1'b1; settle();
        chk("mr_boot_valid", 32'(pc_valid), 32'd0);
        tick(); settle();
        chk("mr_run_valid", 32'(pc_valid), 32'd1);
        chk("mr_run_pc", pc, 32'h8000_0000);

        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
